// File: rtl/registro_solicitudes_if.sv
// Signal bundle between the request register and the elevator algorithm FSM.
`timescale 1ns/1ps
interface registro_solicitudes_if;
  // Contract: there is no valid/ready pair on this link. The algorithm presents
  // estado every cycle. While esperar is high it must hold estado stopped, which
  // means estado[3] = 0 and the floor stays the same. solicitudes is a level
  // that the algorithm samples whenever it likes.
  logic [9:0] botones;
  logic [3:0] estado;
  logic [9:0] solicitudes;
  logic       esperar;
  logic       puerta_abierta;
  logic       fsm_dbg;          // door FSM state (0 = CERRADA, 1 = ABIERTA)

  modport master (
    output botones, estado,
    input  solicitudes, esperar, puerta_abierta, fsm_dbg
  );

  modport slave (
    input  botones, estado,
    output solicitudes, esperar, puerta_abierta, fsm_dbg
  );
endinterface

// File: rtl/registro_solicitudes.sv
// Request register and door timer in front of the elevator algorithm FSM.
// The block latches button edges into solicitudes and clears the requests that
// are served when the car stops. It also times the door and raises esperar so
// that the algorithm holds while the door is open or about to open.
`timescale 1ns/1ps
module registro_solicitudes #(
  parameter int T_PUERTA = 50,
  parameter int ANCHO_T  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  registro_solicitudes_if.slave bus
);

  localparam logic [0:0] CERRADA = 1'b0;
  localparam logic [0:0] ABIERTA = 1'b1;
  localparam logic [ANCHO_T-1:0] CNT_RECARGA = ANCHO_T'(T_PUERTA - 1);

  // Input synchronizers, edge history, request register, door FSM
  logic [9:0]         sync1_q, sync2_q, hist_q;
  logic [9:0]         sol_q, sol_d;
  logic               mov_q;
  logic [0:0]         fsm_q, fsm_d;
  logic [ANCHO_T-1:0] cnt_q, cnt_d;

  logic [9:0] pulso;
  logic [1:0] piso;
  logic       sube, moviendo;
  logic       llegada, local_req;
  logic [9:0] bits_piso, mask_llegada;
  logic [9:0] borrar, bloqueo;

  assign pulso    = sync2_q & ~hist_q;
  assign piso     = bus.estado[1:0];
  assign sube     = bus.estado[2];
  assign moviendo = bus.estado[3];

  // All request bits belonging to the current floor (hall calls plus cabin)
  always_comb begin
    bits_piso = '0;
    case (piso)
      2'd0:    bits_piso = 10'b00_0100_0001;
      2'd1:    bits_piso = 10'b00_1000_0110;
      2'd2:    bits_piso = 10'b01_0001_1000;
      default: bits_piso = 10'b10_0010_0000;
    endcase
  end

  // On arrival, clear the cabin bit and only the hall call in the travel direction
  always_comb begin
    mask_llegada = '0;
    case (piso)
      2'd0:    mask_llegada = 10'b00_0100_0001;
      2'd1:    mask_llegada = sube ? 10'b00_1000_0100 : 10'b00_1000_0010;
      2'd2:    mask_llegada = sube ? 10'b01_0001_0000 : 10'b01_0000_1000;
      default: mask_llegada = 10'b10_0010_0000;
    endcase
  end

  // llegada: the car stopped this cycle. local: the car is idle at a floor with
  // a pending request. Neither signal depends on botones.
  assign llegada   = mov_q & ~moviendo;
  assign local_req = ~moviendo & ~mov_q & (fsm_q == CERRADA) & (|(sol_q & bits_piso));

  assign bus.esperar        = (fsm_q == ABIERTA) | llegada | local_req;
  assign bus.puerta_abierta = (fsm_q == ABIERTA);
  assign bus.solicitudes    = sol_q;
  assign bus.fsm_dbg        = fsm_q;

  // Door FSM next state, door timer, and the request clear/block masks
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    borrar  = '0;
    bloqueo = '0;
    case (fsm_q)
      CERRADA: begin
        cnt_d = '0;
        if (llegada) begin
          fsm_d  = ABIERTA;
          cnt_d  = CNT_RECARGA;
          borrar = mask_llegada;
        end else if (local_req) begin
          fsm_d  = ABIERTA;
          cnt_d  = CNT_RECARGA;
          borrar = bits_piso;
        end
      end
      ABIERTA: begin
        if (moviendo) begin
          // The algorithm should never move with the door open; close at once.
          fsm_d = CERRADA;
          cnt_d = '0;
        end else if (|(pulso & bits_piso)) begin
          // A press at the current floor keeps the door open and is not stored.
          cnt_d   = CNT_RECARGA;
          bloqueo = bits_piso;
        end else if (cnt_q == '0) begin
          fsm_d = CERRADA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        fsm_d = CERRADA;
        cnt_d = '0;
      end
    endcase
    // A cleared bit wins over a press that arrives in the same cycle.
    sol_d = (sol_q | (pulso & ~bloqueo)) & ~borrar;
  end

  // Two-flop synchronizer followed by one history flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= bus.botones;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // State registers: requests, previous moving flag, door FSM and timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sol_q <= '0;
      mov_q <= 1'b0;
      fsm_q <= CERRADA;
      cnt_q <= '0;
    end else begin
      sol_q <= sol_d;
      mov_q <= moviendo;
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
